// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared definitions for the MIPS register file slice. It holds the
//            width defaults, the hardwired-zero register index and a helper
//            that extracts one port's field from a packed multi-port bus.
// Ports    : none (package)
// Config   : REGFILE_BYPASS_EN (consumed by mips_regfile_sb)
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int REG_ZERO    = 0;

  // Widest single field and widest packed bus the slice helper handles
  // (up to 4 ports of up to 64 bits each).
  localparam int SLICE_MAX_W = 64;
  localparam int VEC_MAX_W   = 4 * SLICE_MAX_W;

  // Returns field idx of width 'width' from a packed bus. The caller
  // zero-extends the bus to VEC_MAX_W and truncates the result to the real
  // field width with a size cast.
  function automatic logic [SLICE_MAX_W-1:0] port_slice(
    input logic [VEC_MAX_W-1:0] vec,
    input int                   idx,
    input int                   width
  );
    logic [VEC_MAX_W-1:0] shifted;
    shifted = vec >> (idx * width);
    return shifted[SLICE_MAX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_sb_busy.sv
`default_nettype none
// ============================================================================
// Module   : mips_sb_busy
// Purpose  : Scoreboard of in-flight destination registers. One busy bit per
//            register: an issue sets it, a writeback clears it, and a set
//            beats a clear on the same index. Also keeps a registered
//            population count of the busy vector.
// Ports    : clk, rst (async, active-low)
//            iss_valid/iss_addr : destination issued from ID
//            wen/waddr          : writeback clearing a producer
//            busy               : current busy vector
//            pend_cnt           : number of busy registers
// Revision : 1.0  initial release
// ============================================================================
module mips_sb_busy
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  output logic [(1<<ADDR_W)-1:0]  busy,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int c_depth = 1 << ADDR_W;

  logic [c_depth-1:0] r_busy;
  logic [ADDR_W:0]    r_pend;
  logic [c_depth-1:0] w_busy_nxt;
  logic [ADDR_W:0]    w_cnt_nxt;
  logic               w_iss_ok;

  assign w_iss_ok = iss_valid &&
                    !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));

  always_comb begin
    w_busy_nxt = r_busy;
    // Clear first so that a same-index issue overrides it: the newer
    // producer is still in flight.
    if (wen)
      w_busy_nxt[waddr] = 1'b0;
    if (w_iss_ok)
      w_busy_nxt[iss_addr] = 1'b1;

    // Count the post-edge vector so pend_cnt changes on the same edge as busy.
    w_cnt_nxt = '0;
    for (int j = 0; j < c_depth; j++)
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[j]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_pend <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_pend <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign pend_cnt = r_pend;

endmodule
`default_nettype wire

// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_sb
// Purpose  : Multi-read-port register file with optional hardwired zero
//            register, optional write-through bypass and an integrated
//            scoreboard producing a per-port busy flag and an ID-stage stall.
// Ports    : clk, rst (async, active-low)
//            rd_en/rd_addr/rd_data/rd_busy : NUM_RD packed read ports
//            stall                         : OR of rd_en & rd_busy
//            wen/waddr/wdata               : writeback port
//            iss_valid/iss_addr            : destination issue from ID
//            pend_cnt                      : number of busy registers
// Config   : REGFILE_BYPASS_EN - when defined, a same-cycle writeback is
//            forwarded to matching read ports and masks their busy flag.
// Revision : 1.0  initial release
// ============================================================================
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0]  r_regs [c_depth];
  logic [c_depth-1:0] w_busy;
  logic               w_wen;
  logic               w_wr_ok;

  // Nothing is written or forwarded while reset is held.
  assign w_wen   = wen && rst;
  assign w_wr_ok = w_wen &&
                   !((ZERO_REG != 0) && (waddr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < c_depth; k++)
        r_regs[k] <= '0;
    end else if (w_wr_ok) begin
      r_regs[waddr] <= wdata;
    end
  end

  mips_sb_busy #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb_busy (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wen       (w_wen),
    .waddr     (waddr),
    .busy      (w_busy),
    .pend_cnt  (pend_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_hit;

    assign w_addr = ADDR_W'(port_slice(VEC_MAX_W'(rd_addr), i, ADDR_W));
    assign w_zero = (ZERO_REG != 0) && (w_addr == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    assign w_hit = w_wen && (waddr == w_addr);
`else
    assign w_hit = 1'b0;
`endif

    // Zero register has priority over the bypass, so a discarded write to
    // index 0 is never forwarded.
    assign rd_data[i*DATA_W +: DATA_W] = w_zero ? '0 :
                                         w_hit  ? wdata : r_regs[w_addr];
    // A writeback landing this cycle resolves the hazard via the bypass.
    assign rd_busy[i] = w_busy[w_addr] & ~w_hit;
  end

  assign stall = |(rd_en & rd_busy);

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_sb
// Purpose  : Self-checking bench for mips_regfile_sb (default parameters).
//            A behavioural model (register array + busy array) predicts every
//            output; directed steps are followed by a randomized phase.
// Config   : REGFILE_BYPASS_EN selects the forwarding expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 1 << AW;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              stall;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic [AW:0]       pend_cnt;

  mips_regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .stall     (stall),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mregs [DEPTH];
  bit            mbusy [DEPTH];
  int            checks = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && rst && wen && waddr == a) return wdata;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return mbusy[a] && !(BYP && rst && wen && waddr == a);
  endfunction

  function automatic logic [AW:0] exp_pend();
    int n = 0;
    for (int j = 0; j < DEPTH; j++) n += int'(mbusy[j]);
    return (AW+1)'(n);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) begin
      mregs[j] = '0;
      mbusy[j] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] a;
    logic          est;
    est = 1'b0;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      checks++;
      assert (rd_data[p*DW +: DW] === exp_data(a)) else begin
        failures++;
        $error("FAIL %s rd_data[%0d] addr=%0d got=%h exp=%h", tag, p, a,
               rd_data[p*DW +: DW], exp_data(a));
      end
      checks++;
      assert (rd_busy[p] === exp_busy(a)) else begin
        failures++;
        $error("FAIL %s rd_busy[%0d] addr=%0d got=%b exp=%b", tag, p, a,
               rd_busy[p], exp_busy(a));
      end
      est = est | (rd_en[p] & exp_busy(a));
    end
    checks++;
    assert (stall === est) else begin
      failures++;
      $error("FAIL %s stall got=%b exp=%b", tag, stall, est);
    end
    checks++;
    assert (pend_cnt === exp_pend()) else begin
      failures++;
      $error("FAIL %s pend_cnt got=%0d exp=%0d", tag, pend_cnt, exp_pend());
    end
  endtask

  // Apply current inputs for one cycle: check before the edge, then advance
  // the model with the values sampled at the edge.
  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    if (rst) begin
      if (wen && waddr != 0) mregs[waddr] = wdata;
      if (wen) mbusy[waddr] = 1'b0;
      if (iss_valid && iss_addr != 0) mbusy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; iss_valid = 1'b0; waddr = '0; wdata = '0; iss_addr = '0;
  endtask

  task automatic rd(input int a0, input int a1, input logic [NR-1:0] en);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
    rd_en = en;
  endtask

  initial begin
    model_reset();
    // Reset held with an attempted write to r3
    rst = 1'b0;
    idle();
    wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_DEAD;
    rd(3, 3, 2'b11);
    cyc("reset_hold");
    cyc("reset_hold2");
    rst = 1'b1;
    idle();
    cyc("reset_rel_r3");

    // Write / read
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; rd(5, 5, 2'b00);
    cyc("wr_r5");
    idle(); cyc("rd_r5_both");
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; rd(0, 0, 2'b11);
    cyc("wr_r0");
    idle(); cyc("rd_r0");

    // Bypass (or its absence) on r7
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; rd(7, 5, 2'b01);
    cyc("bypass_r7");
    idle(); cyc("after_r7");

    // Scoreboard stall on r9
    iss_valid = 1'b1; iss_addr = 5'd9; rd(0, 9, 2'b10);
    cyc("iss_r9");
    idle(); cyc("busy_r9");
    wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
    cyc("wb_r9");
    idle(); cyc("clr_r9");

    // Simultaneous set and clear on r4
    iss_valid = 1'b1; iss_addr = 5'd4; wen = 1'b1; waddr = 5'd4;
    wdata = 32'h4444_0004; rd(4, 4, 2'b11);
    cyc("setclr_r4");
    idle(); cyc("after_setclr_r4");
    wen = 1'b1; waddr = 5'd4; wdata = 32'h4; cyc("clr_r4");
    idle(); cyc("idle_r4");

    // Saturation: issue every register including r0, then re-issue r1 (WAW)
    for (int r = 0; r < DEPTH; r++) begin
      iss_valid = 1'b1; iss_addr = AW'(r); rd(r, 0, 2'b01);
      cyc("sat_issue");
    end
    iss_addr = 5'd1; cyc("sat_waw");
    idle(); rd(31, 1, 2'b11); cyc("sat_full");
    for (int r = 1; r < DEPTH; r++) begin
      wen = 1'b1; waddr = AW'(r); wdata = DW'(r * 3); rd(r, r, 2'b11);
      cyc("sat_clear");
    end
    idle(); cyc("sat_empty");

    // Randomized phase with addresses concentrated on a few registers
    for (int n = 0; n < 400; n++) begin
      wen       = ($urandom_range(0, 1) == 1);
      waddr     = AW'($urandom_range(0, 7));
      wdata     = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = AW'($urandom_range(0, 7));
      rd($urandom_range(0, 7), $urandom_range(0, 7), NR'($urandom_range(0, 3)));
      cyc("rand");
    end

    // Asynchronous reset mid-operation, then resume
    wen = 1'b1; waddr = 5'd2; wdata = 32'h2222_2222;
    iss_valid = 1'b1; iss_addr = 5'd3; rd(2, 3, 2'b11);
    #3 rst = 1'b0;
    model_reset();
    cyc("midrst");
    rst = 1'b1; idle(); cyc("midrst_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
